// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
//   state_t   : loader FSM states
//   SYNC_BYTE : frame start marker
//   LEN_W     : width of the frame length field
package imem_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        CLEAR,
        DATA,
        CSUM,
        RUN,
        HALTED,
        ERROR
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         LEN_W     = 16;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream channel into the loader.
//   in_valid : source has a byte on in_data
//   in_data  : stream byte
//   in_ready : loader can take a byte this cycle
// Handshake: a byte moves on a rising clk edge where in_valid && in_ready.
// The source keeps in_valid high and in_data stable until that edge; the
// loader may drop in_ready at any time and never looks at in_data otherwise.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader_run_counter.sv
// run_counter: saturating cycle counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (wins over everything but rst)
//   en       : count this cycle
//   hold     : freeze the count even if en is high
//   count    : current value, sticks at all-ones
module run_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             hold,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !hold && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (A5, LEN_HI, LEN_LO, payload,
// XOR checksum), writes the payload into the byte-addressed instruction
// memory and releases the CPU from reset once a frame checks out.
//   clk, rst     : clock, synchronous active-high reset
//   s            : byte-stream slave (in_valid/in_data/in_ready)
//   instructions : memory image, byte a at instructions[a]
//   cpu_rst_n    : active-low CPU reset, high only in RUN/HALTED
//   cpu_halted   : CPU reports halt
//   busy         : a frame is being loaded
//   done         : program loaded and CPU released
//   error        : last frame rejected (sticky until next SYNC)
//   run_cycles   : clk cycles spent in RUN
//   state_dbg    : current FSM state
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int M     = 10,
    parameter int CNT_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    imem_loader_if.slave                s,
    output logic [4*(2**M)-1:0][7:0]    instructions,
    output logic                        cpu_rst_n,
    input  logic                        cpu_halted,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [CNT_W-1:0]            run_cycles,
    output state_t                      state_dbg
);

    localparam int              MEM_BYTES  = 4 * (2 ** M);
    localparam int              AW         = M + 2;
    localparam logic [31:0]     MEM_BYTES_W = 32'(MEM_BYTES);
    localparam logic [LEN_W-1:0] CLEAR_LAST = LEN_W'(MEM_BYTES - 1);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] addr;
    logic [7:0]       csum;
    logic             acc;
    logic             is_sync;
    logic [LEN_W-1:0] len_val;
    logic             len_bad;
    logic             reload;
    logic             wr_en;
    logic [7:0]       wr_data;

    assign s.in_ready = !rst && (state != CLEAR);
    assign acc        = s.in_valid && s.in_ready;
    assign is_sync    = acc && (s.in_data == SYNC_BYTE);
    assign state_dbg  = state;

    // Full length as it will be once LEN_LO is latched.
    assign len_val = {len[LEN_W-1:8], s.in_data};
    assign len_bad = (len_val == '0) || (len_val[1:0] != 2'b00) ||
                     ({{(32-LEN_W){1'b0}}, len_val} > MEM_BYTES_W);

    // SYNC only means "start a frame" in the states that are not mid-frame;
    // inside DATA an A5 is ordinary payload.
    assign reload = is_sync &&
                    (state inside {IDLE, RUN, HALTED, ERROR});

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (is_sync) state_nxt = LEN_HI;
            LEN_HI:  if (acc) state_nxt = LEN_LO;
            LEN_LO:  if (acc) state_nxt = len_bad ? ERROR : CLEAR;
            CLEAR:   if (addr == CLEAR_LAST) state_nxt = DATA;
            DATA:    if (acc && ((addr + LEN_W'(1)) == len)) state_nxt = CSUM;
            CSUM:    if (acc) state_nxt = (s.in_data == csum) ? RUN : ERROR;
            RUN: begin
                if (is_sync)         state_nxt = LEN_HI;
                else if (cpu_halted) state_nxt = HALTED;
            end
            HALTED:  if (is_sync) state_nxt = LEN_HI;
            ERROR:   if (is_sync) state_nxt = LEN_HI;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            len       <= '0;
            addr      <= '0;
            csum      <= '0;
        end else begin
            state     <= state_nxt;
            cpu_rst_n <= state_nxt inside {RUN, HALTED};
            done      <= state_nxt inside {RUN, HALTED};
            busy      <= state_nxt inside {LEN_HI, LEN_LO, CLEAR, DATA, CSUM};
            error     <= (state_nxt == ERROR);
            case (state)
                LEN_HI: if (acc) len[LEN_W-1:8] <= s.in_data;
                LEN_LO: begin
                    if (acc) begin
                        len[7:0] <= s.in_data;
                        addr     <= '0;
                        csum     <= '0;
                    end
                end
                // addr sweeps the whole memory, then restarts at 0 for DATA.
                CLEAR:  addr <= (addr == CLEAR_LAST) ? '0 : addr + LEN_W'(1);
                DATA: begin
                    if (acc) begin
                        addr <= addr + LEN_W'(1);
                        csum <= csum ^ s.in_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory is deliberately not reset: a reset mid-frame keeps what was
    // already written, and CLEAR wipes it before the next load.
    assign wr_en   = !rst && ((state == CLEAR) || ((state == DATA) && acc));
    assign wr_data = (state == DATA) ? s.in_data : 8'h00;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            instructions[addr[AW-1:0]] <= wr_data;
        end
    end

    run_counter #(.CNT_W(CNT_W)) u_run_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (reload),
        .en    (state == RUN),
        .hold  (state == HALTED),
        .count (run_cycles)
    );

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized bench for imem_loader with a frame-level
// reference model and per-cycle output comparison.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int M  = 4;
    localparam int MB = 64;
    localparam int CW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_halted = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if dif ();

    logic [MB-1:0][7:0] instructions;
    logic               cpu_rst_n, busy, done, error;
    logic [CW-1:0]      run_cycles;
    state_t             state_dbg;

    imem_loader #(.M(M), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .s            (dif),
        .instructions (instructions),
        .cpu_rst_n    (cpu_rst_n),
        .cpu_halted   (cpu_halted),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .run_cycles   (run_cycles),
        .state_dbg    (state_dbg)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks where we are in the frame, the memory image and run time.
    localparam int MD_IDLE = 0, MD_HI = 1, MD_LO = 2, MD_CLR = 3, MD_DAT = 4,
                   MD_CS = 5, MD_RUN = 6, MD_HLT = 7, MD_ERR = 8;
    int          md = MD_IDLE;
    int          m_len, m_idx;
    logic [7:0]  m_hi, m_sum;
    logic [7:0]  m_mem [MB];
    bit          m_known = 1'b0;
    logic [CW-1:0] m_run = '0;
    logic [MB-1:0][7:0] exp_mem;

    function automatic bit m_ready();
        return !rst && (md != MD_CLR);
    endfunction

    always @(posedge clk) begin
        bit         acc;
        logic [7:0] d;
        acc = dif.in_valid && m_ready();
        d   = dif.in_data;
        if (rst) begin
            md    = MD_IDLE;
            m_run = '0;
        end else begin
            case (md)
                MD_IDLE: if (acc && d == 8'hA5) md = MD_HI;
                MD_HI: if (acc) begin m_hi = d; md = MD_LO; end
                MD_LO: if (acc) begin
                    m_len = int'(m_hi) * 256 + int'(d);
                    if (m_len == 0 || (m_len % 4) != 0 || m_len > MB) md = MD_ERR;
                    else begin md = MD_CLR; m_idx = 0; m_sum = 8'h00; end
                end
                MD_CLR: begin
                    m_mem[m_idx] = 8'h00;
                    m_idx++;
                    if (m_idx == MB) begin md = MD_DAT; m_idx = 0; m_known = 1'b1; end
                end
                MD_DAT: if (acc) begin
                    m_mem[m_idx] = d;
                    m_sum = m_sum ^ d;
                    m_idx++;
                    if (m_idx == m_len) md = MD_CS;
                end
                MD_CS: if (acc) md = (d == m_sum) ? MD_RUN : MD_ERR;
                MD_RUN: begin
                    if (acc && d == 8'hA5) begin md = MD_HI; m_run = '0; end
                    else begin
                        if (m_run != '1) m_run = m_run + 1;
                        if (cpu_halted) md = MD_HLT;
                    end
                end
                default: if (acc && d == 8'hA5) begin md = MD_HI; m_run = '0; end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("in_ready", dif.in_ready, m_ready());
            check("cpu_rst_n", cpu_rst_n, (md == MD_RUN || md == MD_HLT));
            check("done", done, (md == MD_RUN || md == MD_HLT));
            check("busy", busy, (md >= MD_HI && md <= MD_CS));
            check("error", error, (md == MD_ERR));
            check("run_cycles", run_cycles, m_run);
            if (m_known) begin
                int first;
                first = -1;
                for (int i = 0; i < MB; i++) begin
                    exp_mem[i] = m_mem[i];
                    if (first < 0 && instructions[i] !== m_mem[i]) first = i;
                end
                total++;
                if (instructions !== exp_mem) begin
                    bad++;
                    $display("FAIL mem: byte %0d got %0h want %0h", first,
                             instructions[first], m_mem[first]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        dif.in_valid = 1'b0;
        repeat (gap) begin
            dif.in_data = 8'($urandom);
            @(posedge clk); #1;
        end
        dif.in_valid = 1'b1;
        dif.in_data  = b;
        w = 0;
        @(negedge clk);
        while (!dif.in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (w >= 300) begin
            bad++;
            $display("FAIL accept_timeout: byte %0h waited %0d cycles, want accept", b, w);
        end
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
    endtask

    task automatic send_tail(input logic [7:0] pl[$], input logic [7:0] mask, input int gmax);
        logic [7:0] cs;
        cs = 8'h00;
        foreach (pl[i]) begin
            cs = cs ^ pl[i];
            send_byte(pl[i], $urandom_range(0, gmax));
        end
        send_byte(cs ^ mask, $urandom_range(0, gmax));
    endtask

    task automatic send_frame(input logic [7:0] pl[$], input logic [7:0] mask, input int gmax);
        logic [15:0] ln;
        ln = 16'(pl.size());
        send_byte(8'hA5, $urandom_range(0, gmax));
        send_byte(ln[15:8], $urandom_range(0, gmax));
        send_byte(ln[7:0], $urandom_range(0, gmax));
        send_tail(pl, mask, gmax);
    endtask

    task automatic rand_payload(input int n, output logic [7:0] pl[$]);
        pl = {};
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] pl[$];
        logic [7:0] stream[$];
        int n;

        dif.in_valid = 1'b0;
        dif.in_data  = 8'h00;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_in_ready", dif.in_ready, 0);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_run", run_cycles, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: basic frame
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_frame(pl, 8'h00, 0);
        check("t1_cpu_rst_n", cpu_rst_n, 1);
        check("t1_done", done, 1);
        check("t1_b0", instructions[0], 8'h11);
        check("t1_b7", instructions[7], 8'h88);
        check("t1_b8", instructions[8], 8'h00);
        check("t1_b63", instructions[63], 8'h00);

        // 2: same frame, CSUM byte 00 (correct is 88)
        send_frame(pl, 8'h88, 0);
        check("t2_error", error, 1);
        check("t2_cpu_rst_n", cpu_rst_n, 0);
        check("t2_done", done, 0);
        check("t2_b3", instructions[3], 8'h44);

        // 3: bad lengths, then a full-memory frame
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h06, 0);
        check("t3_len6_error", error, 1);
        check("t3_len6_ready", dif.in_ready, 1);
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h44, 0);
        check("t3_len68_error", error, 1);
        rand_payload(64, pl);
        send_frame(pl, 8'h00, 0);
        check("t3_full_done", done, 1);
        check("t3_b63", instructions[63], pl[63]);

        // 4: halt after 10 RUN cycles, then reload
        rand_payload(4, pl);
        send_frame(pl, 8'h00, 0);
        repeat (9) @(posedge clk);
        #1 cpu_halted = 1'b1;
        @(posedge clk); #1;
        cpu_halted = 1'b0;
        check("t4_run10", run_cycles, 10);
        check("t4_state", state_dbg, HALTED);
        repeat (5) @(posedge clk);
        #1 check("t4_run_held", run_cycles, 10);
        send_byte(8'hA5, 0);
        check("t4_reload_cpu_rst_n", cpu_rst_n, 0);
        check("t4_reload_run", run_cycles, 0);
        check("t4_reload_busy", busy, 1);
        send_byte(8'h00, 0);
        send_byte(8'h08, 0);
        n = 0;
        @(negedge clk);
        while (!dif.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("t4_clear_cycles", n, 64);
        @(posedge clk); #1;
        rand_payload(8, pl);
        send_tail(pl, 8'h00, 0);
        check("t4_done", done, 1);

        // 5: leading junk, gaps
        stream = '{8'h3C, 8'h00, 8'hA5, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        foreach (stream[i]) send_byte(stream[i], $urandom_range(0, 3));
        check("t5_b0", instructions[0], 8'hDE);
        check("t5_b1", instructions[1], 8'hAD);
        check("t5_b2", instructions[2], 8'hBE);
        check("t5_b3", instructions[3], 8'hEF);
        check("t5_state", state_dbg, RUN);

        // 6: reset in the middle of DATA
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h08, 0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_ready", dif.in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_cpu_rst_n", cpu_rst_n, 0);
        check("t6_done", done, 0);
        check("t6_error", error, 0);
        rand_payload(8, pl);
        send_frame(pl, 8'h00, 2);
        check("t6_final_cpu_rst_n", cpu_rst_n, 1);

        // random frames
        for (int k = 0; k < 6; k++) begin
            logic [7:0] mask;
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            if ($urandom_range(0, 1) == 1) send_byte(8'h5A, 1);
            rand_payload(4 * $urandom_range(1, 8), pl);
            send_frame(pl, mask, 2);
            check("rand_done", done, (mask == 8'h00));
            check("rand_error", error, (mask != 8'h00));
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1 chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: time limit reached, want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the CPU's instruction-memory interface. It receives a framed byte stream, fills the byte-addressed instruction memory, and drives that memory to the CPU as its `instructions` array. It holds the CPU in its active-low reset until a load completes with a valid checksum, then tracks execution until the CPU reports halt. Re-sending a frame reloads the program at any time.

Parameters:
M, 10, log2 of instruction word count; the memory holds 4*(2**M) bytes
CNT_W, 32, width of the run-cycle counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  source has a byte on in_data
in_data  in  8  stream byte
in_ready  out  1  loader accepts in_data this cycle
instructions  out  8 x 4*(2**M)  byte array feeding the CPU `instructions` input; byte at address a is instructions[a]
cpu_rst_n  out  1  active-low reset to the CPU
cpu_halted  in  1  CPU is_halted
busy  out  1  frame load in progress
done  out  1  program loaded and CPU released
error  out  1  last frame rejected
run_cycles  out  CNT_W  clk cycles spent in RUN

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- rst=1 at a clk edge: state=IDLE, cpu_rst_n=0, busy=0, done=0, error=0, run_cycles=0. in_ready=0 while rst is high.
- The instructions array is not reset. CLEAR zeroes it before every load.
- A byte is accepted on a cycle where in_valid&&in_ready. in_ready is a decode of state: it is 1 in every state except CLEAR.
- Frame format: SYNC(0xA5), LEN_HI, LEN_LO, LEN payload bytes, CSUM. CSUM is the XOR of all payload bytes.
- Payload byte k is written to instructions[k]. The CPU fetches {mem[pc],mem[pc+1],mem[pc+2],mem[pc+3]}, so the first payload byte is the MSB of word 0.
- States and transitions:
  - IDLE: an accepted byte equal to 0xA5 goes to LEN_HI. Any other byte is dropped.
  - LEN_HI: the accepted byte is latched as len[15:8]. Go to LEN_LO.
  - LEN_LO: latch len[7:0]. If len==0, or len[1:0]!=0, or len>4*(2**M), go to ERROR. Otherwise go to CLEAR with addr=0 and csum=0.
  - CLEAR: write 0 to instructions[addr] and increment addr, one byte per cycle, for 4*(2**M) cycles. Then go to DATA with addr=0.
  - DATA: each accepted byte is written to instructions[addr]; addr increments and csum^=byte. After the len-th byte, go to CSUM.
  - CSUM: if the accepted byte equals csum, go to RUN. Otherwise go to ERROR.
  - RUN: cpu_rst_n=1 and done=1. run_cycles increments every cycle and saturates at all-ones. cpu_halted=1 goes to HALTED.
  - HALTED: cpu_rst_n=1, done=1, run_cycles frozen.
  - ERROR: error=1 and cpu_rst_n=0. error stays sticky until the next SYNC or rst.
- A SYNC byte accepted in RUN, HALTED or ERROR starts a reload: next state LEN_HI, cpu_rst_n=0 from the next cycle, done=0, error=0, run_cycles=0. Non-SYNC bytes in these states are dropped.
- busy=1 in LEN_HI, LEN_LO, CLEAR, DATA and CSUM.
- All outputs are registered from the state and update one cycle after the accepting edge.
  - cpu_rst_n rises in the cycle after the matching CSUM is accepted.
  - A memory write becomes visible the cycle after its accept.
- rst mid-frame abandons the load. Memory keeps partial contents, and cpu_rst_n stays 0 until a full valid frame completes.
- Gaps with in_valid=0 are allowed in any state and have no effect.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, CLEAR, DATA, CSUM, RUN, HALTED, ERROR);
  - SYNC_BYTE=8'hA5;
  - LEN_W=16.
- One sub-module, run_counter: a saturating CNT_W counter with clear, enable and hold inputs.

Test Plan (M=4, so the memory is 64 bytes):
1. Reset, then send A5 00 08 11 22 33 44 55 66 77 88 88. After CLEAR, bytes 0..7 hold 11..88 and bytes 8..63 hold 00. cpu_rst_n=1 and done=1 the cycle after the last byte is accepted.
2. Same frame with CSUM=00: error=1, cpu_rst_n stays 0, done=0, and the payload is in memory.
3. A5 00 06: error=1 immediately after LEN_LO, with no CLEAR cycles. A5 00 44 (68>64): error=1. A5 00 40 plus 64 bytes plus a correct CSUM: accepted, and byte 63 holds the last payload byte.
4. Load a valid frame, then assert cpu_halted after 10 RUN cycles: state HALTED, run_cycles=10 and held there. Then send A5: cpu_rst_n=0 and run_cycles=0 on the next cycle, busy=1, and in_ready=0 for exactly 64 CLEAR cycles after LEN_LO.
5. Send 3C 00 A5 00 04 DE AD BE EF 22 with random in_valid gaps: the leading 3C 00 are ignored, memory bytes 0..3 are DE AD BE EF, and RUN is entered.
6. Assert rst mid-DATA (after 3 of 8 bytes): all outputs return to reset values next cycle. A following valid frame loads correctly, ending with cpu_rst_n=1.
